// File: rtl/data_mem_responder.sv
// Word-addressed multi-cycle data RAM that answers one CPU load/store at a time after WAIT_CYCLES wait states.
// Optional misalignment rejection is enabled by defining DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  dbg_state
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Handshake: a request transfers on a posedge where req_valid & req_ready;
    // req_ready is high only in IDLE out of reset, and the CPU must hold the
    // request stable until it transfers. Responses have no back-pressure.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  acc_we;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] acc_idx;

    assign req_ready  = (state_q == IDLE) && rst_n;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign dbg_state  = state_q;

    // With zero wait states the array is accessed on the accept edge itself,
    // before the request has been latched, so the live inputs are used.
    assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
    assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign acc_idx   = acc_addr[ADDR_WIDTH+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign acc_err = (|acc_addr[31:ADDR_WIDTH+2]) || (|acc_addr[1:0]);
`else
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^acc_addr[1:0];
    assign acc_err = |acc_addr[31:ADDR_WIDTH+2];
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        rdata_d    = rdata_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_we) ? 32'd0 : mem[acc_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
        end
    end

    // The array is never cleared; a reset during WAIT drops the pending store.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end
endmodule
